// File: rtl/d_reg_pipe.sv
// ---------------------------------------------------------------------------
// d_reg_pipe
//
// A WIDTH-bit, DEPTH-stage register pipeline. It is used as a fixed-latency
// delay line and retiming stage between datapath blocks. Each stage carries a
// valid tag, and the block keeps a running count of how many stages hold
// valid data.
//
// Data captured on an enabled edge appears on q after exactly DEPTH enabled
// edges. Stalled cycles (en=0) do not add to the latency. Invalid data still
// shifts through the pipe, and its valid tag marks it as invalid. The block
// has no backpressure. When the pipe is full, each new entry pushes out the
// oldest one.
//
// Parameters:
//   WIDTH      data width in bits (>=1)
//   DEPTH      number of stages, equal to the latency in enabled cycles (>=1)
//   RESET_VAL  value loaded into every data stage on reset and clear
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset (0 = reset asserted)
//   en          advance enable; 0 stalls the whole pipe
//   clr         synchronous clear; flushes all stages (takes priority over en)
//   d           data in
//   d_valid     marks d as valid
//   q           data from the last stage
//   q_valid     valid tag of the last stage
//   count       number of valid stages currently held
//   full        count == DEPTH
//   empty       count == 0
//   parity_err  (DREG_PARITY_EN only) registered parity check on the last stage
//
// Optional feature:
//   Define DREG_PARITY_EN to add a parity bit to every stage and to add the
//   parity_err output. When the macro is undefined, the block has no parity
//   storage and no parity_err port.
// ---------------------------------------------------------------------------
module d_reg_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
`ifdef DREG_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    logic [WIDTH-1:0] s [DEPTH];
    logic [DEPTH-1:0] v;

    // Data stages, valid tags and occupancy count.
    // Priority order: clr, then en, then hold. The count update uses the
    // pre-edge valid tag of the last stage. An entry is added when d_valid is
    // set, and an entry is removed when a valid entry leaves the last stage.
    // Because of this, the count always equals the number of valid tags that
    // are set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= RESET_VAL;
            end
            v     <= '0;
            count <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= RESET_VAL;
            end
            v     <= '0;
            count <= '0;
        end else if (en) begin
            s[0] <= d;
            v[0] <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                s[i] <= s[i-1];
                v[i] <= v[i-1];
            end
            count <= count + CW'(d_valid) - CW'(v[DEPTH-1]);
        end
    end

    assign q       = s[DEPTH-1];
    assign q_valid = v[DEPTH-1];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

`ifdef DREG_PARITY_EN
    logic [DEPTH-1:0] p;

    // A parity bit travels with each data stage and follows the same
    // reset, clear and hold rules as the data stages. When a valid entry
    // leaves the last stage, its data is checked against its parity bit.
    // A mismatch means the stored data was corrupted somewhere in the pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p          <= '0;
            parity_err <= 1'b0;
        end else if (clr) begin
            p          <= '0;
            parity_err <= 1'b0;
        end else if (en) begin
            p[0] <= ^d;
            for (int i = 1; i < DEPTH; i++) begin
                p[i] <= p[i-1];
            end
            parity_err <= v[DEPTH-1] & ((^s[DEPTH-1]) != p[DEPTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_d_reg_pipe.sv
// ---------------------------------------------------------------------------
// tb_d_reg_pipe
//
// Scoreboard bench for d_reg_pipe (WIDTH=8, DEPTH=4).
//
// The reference model treats the pipe as a queue of DEPTH entries. Each entry
// holds its data, its valid flag and a "corrupted" flag. An enabled edge
// pushes a new entry at the front and drops the oldest entry. A clear resets
// every entry. The driver pushes the expected post-edge outputs into a queue,
// and the monitor pops and compares them shortly after every rising edge.
// ---------------------------------------------------------------------------
module tb_d_reg_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic             en      = 1'b0;
    logic             clr     = 1'b0;
    logic [WIDTH-1:0] d       = '0;
    logic             d_valid = 1'b0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
`ifdef DREG_PARITY_EN
    logic             parity_err;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             valid;
        logic             bad;
    } ent_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             qv;
        int               cnt;
        logic             perr;
    } exp_t;

    ent_t pipe_m[$];
    logic perr_m;
    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   check_cnt = 0;

    d_reg_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .d          (d),
        .d_valid    (d_valid),
        .q          (q),
        .q_valid    (q_valid),
        .count      (count),
        .full       (full),
        .empty      (empty)
`ifdef DREG_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Single comparison; also steps the pass and total counters
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Empty the model pipe back to its reset contents
    task automatic modelReset();
        pipe_m.delete();
        for (int i = 0; i < DEPTH; i++) pipe_m.push_back('{data: '0, valid: 1'b0, bad: 1'b0});
        perr_m = 1'b0;
    endtask

    function automatic int modelCount();
        int n = 0;
        foreach (pipe_m[i]) if (pipe_m[i].valid) n++;
        return n;
    endfunction

    // Drive one cycle of inputs at the falling edge, advance the model for
    // the coming rising edge, and queue the outputs expected after that edge
    task automatic applyStimulus(input logic ien, input logic iclr,
                                 input logic [WIDTH-1:0] id, input logic idv);
        exp_t e;
        ent_t last;
        @(negedge clk);
        en = ien; clr = iclr; d = id; d_valid = idv;
        if (iclr) begin
            modelReset();
        end else if (ien) begin
            last   = pipe_m[DEPTH-1];
            perr_m = last.valid & last.bad;
            pipe_m.push_front('{data: id, valid: idv, bad: 1'b0});
            void'(pipe_m.pop_back());
        end
        e.q    = pipe_m[DEPTH-1].data;
        e.qv   = pipe_m[DEPTH-1].valid;
        e.cnt  = modelCount();
        e.perr = perr_m;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        chk("q", 32'(q), 32'(e.q));
        chk("q_valid", 32'(q_valid), 32'(e.qv));
        chk("count", 32'(count), e.cnt);
        chk("full", 32'(full), 32'(e.cnt == DEPTH));
        chk("empty", 32'(empty), 32'(e.cnt == 0));
`ifdef DREG_PARITY_EN
        chk("parity_err", 32'(parity_err), 32'(e.perr));
`endif
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_q"}, 32'(q), 32'h00);
        chk({tag, "_q_valid"}, 32'(q_valid), 32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_empty"}, 32'(empty), 32'h1);
        chk({tag, "_full"}, 32'(full), 32'h0);
    endtask

    // Monitor: compare against the scoreboard shortly after every rising edge
    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        modelReset();

        // Power-on reset with busy inputs; everything must stay cleared
        d = 8'hFF; en = 1'b1; d_valid = 1'b1;
        #24;
        checkReset("por");
        #4;
        reset = 1'b1;

        // Enabled edges with no valid data keep the count at zero
        repeat (4) applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);

        // Latency: 11 appears after the 4th enabled edge, then 22, 33, 44
        applyStimulus(1'b1, 1'b0, 8'h11, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h22, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h44, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

        // Stall: A5 captured, 3 stalled cycles, then 3 enabled edges to reach q
        applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h3C, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

        // Clear precedence over a full pipe; 77 must never be captured
        repeat (4) applyStimulus(1'b1, 1'b0, 8'(32'($urandom)), 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

        // Randomized traffic with occasional stalls and clears
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 20) == 0,
                          8'(32'($urandom)), 1'($urandom));
        end

        // Asynchronous reset 3 ns after an edge, with count at 3
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 8'(32'($urandom)), 1'b1);
        @(posedge clk);
        #3;
        en = 1'b0; d_valid = 1'b0;
        reset = 1'b0;
        #1;
        checkReset("async");
        #3;
        reset = 1'b1;
        modelReset();
        // Refill from empty after release
        repeat (6) applyStimulus(1'b1, 1'b0, 8'(32'($urandom)), 1'b1);

`ifdef DREG_PARITY_EN
        // Corrupt stage 2 of a valid entry; the error flags when it leaves
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0, 8'(32'($urandom)), 1'b1);
        @(posedge clk);
        #1;
        dut.s[2][0] = ~dut.s[2][0];
        pipe_m[2].data[0] = ~pipe_m[2].data[0];
        pipe_m[2].bad = 1'b1;
        repeat (4) applyStimulus(1'b1, 1'b0, 8'(32'($urandom)), 1'b1);
`endif

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/d_reg_pipe.md
Name: d_reg_pipe

Overview:
- Parametrised successor to the single-bit reset D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
- Adds a stall enable, a synchronous clear, a per-stage valid tag and an occupancy count.
- Used as a fixed-latency delay line and retiming stage between Basys 3 datapath blocks (switch/button capture to display/logic paths).

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages, which is also the latency in enabled cycles (>=1)
- RESET_VAL, 0, value loaded into every data stage on reset and clear (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- en  input  1  advance enable; 0 stalls the whole pipe
- clr  input  1  synchronous clear; flushes all stages
- d  input  WIDTH  data in
- d_valid  input  1  marks d as valid
- q  output  WIDTH  data from the last stage, s[DEPTH-1]
- q_valid  output  1  valid tag of the last stage
- count  output  CW  number of valid stages currently held; CW = $clog2(DEPTH+1)
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Storage: data stages s[0..DEPTH-1], valid bits v[0..DEPTH-1], count register. All are registered.
- Reset low, asynchronous: immediately s[i]=RESET_VAL, v[i]=0, count=0. Resulting outputs: q=RESET_VAL, q_valid=0, full=0, empty=1. While reset is low, all other inputs are ignored.
- Priority at each posedge: clr > en > hold.
- clr=1: s[i]<=RESET_VAL, v[i]<=0, count<=0. Ignores en, d and d_valid in that cycle.
- en=1, clr=0:
  - s[0]<=d, v[0]<=d_valid.
  - s[i]<=s[i-1] and v[i]<=v[i-1] for i>=1.
  - count <= count + d_valid - v[DEPTH-1], evaluated with the pre-edge v.
- en=0, clr=0: all state holds, including data of invalid stages.
- Latency: d captured on an enabled edge appears on q after exactly DEPTH enabled edges. Stalled cycles do not count toward latency.
- Data stages shift regardless of d_valid. Invalid data is carried through but flagged by v.
- Full with en=1, d_valid=1: the oldest entry is shifted out, having been presented on q the cycle before. count stays DEPTH. There is no overflow or backpressure; the pipe is a delay line, not a FIFO.
- Empty with en=1, d_valid=0: count stays 0. No underflow.
- DEPTH=1: behaves as a single D flip-flop with enable, clear and valid tag. count is 1 bit.
- full and empty are combinational decodes of count. No combinational path from any input to any output.
- count never exceeds DEPTH. count always equals the popcount of v[]; verification checks this as an invariant every cycle.
- Reset asserted mid-stream: all in-flight data is lost immediately, without waiting for a clock edge.
- Reset deassertion: the first posedge after release operates normally. The bench releases reset at least 2 ns away from a clock edge.

Optional Feature:
- Macro: DREG_PARITY_EN
- Defined:
  - A parity bit p[i] travels alongside each stage; p[0] <= ^d on capture.
  - Extra output parity_err (1 bit), registered: on each enabled edge, parity_err <= v[DEPTH-1] & (^s[DEPTH-1] != p[DEPTH-1]).
  - parity_err is cleared by reset and by clr.
  - p[] follows the same reset, clr and hold rules as s[].
- Not defined: no p[] storage and no parity_err port. All other behaviour is identical.

Test Plan:
- Reset/hold (WIDTH=8, DEPTH=4): hold reset low 25 ns with d=8'hFF, en=1 -> q=8'h00, q_valid=0, count=0, empty=1. Release reset, drive 4 enabled edges with d_valid=0 -> count remains 0.
- Latency: release reset, feed d=8'h11,22,33,44 with d_valid=1 on consecutive enabled edges -> q=8'h11 with q_valid=1 after the 4th edge; count=4, full=1; next edges show 22, 33, 44 in order.
- Stall: load 8'hA5 at s[0], hold en=0 for 3 cycles, then en=1 for 3 edges -> 8'hA5 reaches q exactly on the 4th enabled edge; q and count are unchanged during the stall.
- Clear precedence: with the pipe full, assert clr=1 together with en=1, d=8'h77, d_valid=1 -> next edge q=8'h00, q_valid=0, count=0; 8'h77 is not captured.
- Async reset mid-stream: with count=3, pull reset low 3 ns after a posedge -> outputs reset immediately, before the next edge. After release, the pipe refills from empty.
- Parity (DREG_PARITY_EN defined): force-flip one bit of s[2] via hierarchical deposit while v[2]=1 -> parity_err=1 on the edge at which that entry leaves s[DEPTH-1]; otherwise parity_err stays 0.
